// File: rtl/md_unit_if.sv
// Operand/control bundle between the E stage and the multiply/divide unit.
interface md_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDOp;
    logic        start;
    logic        IntReq;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, B, MDOp, start, IntReq, input busy, HI, LO);
    modport slave  (input A, B, MDOp, start, IntReq, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Define MDU_MADD_EN to add the madd/maddu/msub accumulate operations.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;

    typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;
    acc_t r_acc;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [63:0]      r_pend;

    logic             w_accept;
    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic [31:0]      w_quot_s;
    logic [31:0]      w_rem_s;
    logic [31:0]      w_quot_u;
    logic [31:0]      w_rem_u;

    assign w_accept = bus.start & ~bus.IntReq & ~r_busy;
    assign w_prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // NOTE: every output gets a default first so no latch is inferred on untaken paths.
    always_comb begin
        w_quot_s = '0;
        w_rem_s  = '0;
        w_quot_u = '0;
        w_rem_u  = '0;
        if (bus.B != 32'd0) begin
            w_quot_u = bus.A / bus.B;
            w_rem_u  = bus.A % bus.B;
            // Most-negative / -1 overflows; pin it to the wrap-around result.
            if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
                w_quot_s = 32'h8000_0000;
            end else begin
                w_quot_s = $signed(bus.A) / $signed(bus.B);
                w_rem_s  = $signed(bus.A) % $signed(bus.B);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_pend  <= '0;
`ifdef MDU_MADD_EN
            r_acc   <= ACC_NONE;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
`ifdef MDU_MADD_EN
                        r_acc <= ACC_NONE;
`endif
                        case (bus.MDOp)
                            OP_MULT, OP_MULTU: begin
                                r_pend  <= (bus.MDOp == OP_MULT) ? w_prod_s : w_prod_u;
                                r_state <= S_MULT;
                                r_cnt   <= CNT_W'(MULT_CYCLES);
                                r_busy  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (bus.B != 32'd0) begin
                                    r_pend  <= (bus.MDOp == OP_DIV) ? {w_rem_s, w_quot_s}
                                                                    : {w_rem_u, w_quot_u};
                                    r_state <= S_DIV;
                                    r_cnt   <= CNT_W'(DIV_CYCLES);
                                    r_busy  <= 1'b1;
                                end
                            end
                            OP_MTHI: r_hi <= bus.A;
                            OP_MTLO: r_lo <= bus.A;
`ifdef MDU_MADD_EN
                            OP_MADD, OP_MADDU, OP_MSUB: begin
                                r_pend  <= (bus.MDOp == OP_MADDU) ? w_prod_u : w_prod_s;
                                r_acc   <= (bus.MDOp == OP_MSUB) ? ACC_SUB : ACC_ADD;
                                r_state <= S_MULT;
                                r_cnt   <= CNT_W'(MULT_CYCLES);
                                r_busy  <= 1'b1;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                S_MULT, S_DIV: begin
                    if (r_cnt == CNT_W'(1)) begin
`ifdef MDU_MADD_EN
                        case (r_acc)
                            ACC_ADD: {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
                            ACC_SUB: {r_hi, r_lo} <= {r_hi, r_lo} - r_pend;
                            default: {r_hi, r_lo} <= r_pend;
                        endcase
`else
                        {r_hi, r_lo} <= r_pend;
`endif
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
endmodule
